// File: rtl/data_ram_controller.sv
// rtl/data_ram_controller.sv - DEPTH x DATA_WIDTH data RAM with combinational loads, clear sweep and sticky range error
module data_ram_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [ADDR_WIDTH-1:0] dataAddr,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic                  selData,
    input  logic                  ldData,
    input  logic                  clrData,
    output logic                  ready,
    output logic [ADDR_WIDTH-1:0] clrBusyCount,
    output logic                  err
);

    // Array index width; DEPTH never exceeds 2^ADDR_WIDTH so this fits inside an address.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_X  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    err_q, err_d;
    logic                    ready_q, ready_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    in_range;
    logic [IDX_W-1:0]        acc_idx;
    logic [IDX_W-1:0]        clr_idx;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Address decode shared by loads, stores and the range check.
    always_comb begin
        in_range = ({1'b0, dataAddr} < DEPTH_X);
        acc_idx  = dataAddr[IDX_W-1:0];
        clr_idx  = clr_cnt_q[IDX_W-1:0];
    end

    // Next-state logic: clear sweep with restart, IDLE stores and sticky range error.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = acc_idx;
        mem_wdata = dataIn;
        case (state_q)
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_idx;
                mem_wdata = '0;
                if (clrData) begin
                    clr_cnt_d = '0;
                end else if (clr_cnt_q == CNT_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (selData && !in_range) begin
                    err_d = 1'b1;
                end
                if (clrData) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (selData && !ldData && in_range) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Control registers; reset forces a fresh sweep and clears the error flag.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            err_q     <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
        end
    end

    // Single write port; nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (res && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Loads are combinational so data is valid within the same cycle.
    assign dataOut      = (state_q == ST_IDLE && selData && ldData && in_range) ? mem[acc_idx] : '0;
    assign ready        = ready_q;
    assign clrBusyCount = clr_cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_data_ram_controller.sv
// tb/tb_data_ram_controller.sv - randomized self-checking bench against a behavioural RAM model
module tb_data_ram_controller;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic          clk;
    logic          res;
    logic [AW-1:0] dataAddr;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;
    logic          selData;
    logic          ldData;
    logic          clrData;
    logic          ready;
    logic [AW-1:0] clrBusyCount;
    logic          err;

    int pass_cnt;
    int total_cnt;

    logic [DW-1:0] mem_m [DEPTH];
    logic          err_m;

    data_ram_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .res          (res),
        .dataAddr     (dataAddr),
        .dataIn       (dataIn),
        .dataOut      (dataOut),
        .selData      (selData),
        .ldData       (ldData),
        .clrData      (clrData),
        .ready        (ready),
        .clrBusyCount (clrBusyCount),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        selData  = 1'b0;
        ldData   = 1'b0;
        clrData  = 1'b0;
        dataAddr = '0;
        dataIn   = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    endtask

    task automatic do_store(input int addr, input logic [DW-1:0] d);
        selData  = 1'b1;
        ldData   = 1'b0;
        dataAddr = AW'(addr);
        dataIn   = d;
        step();
        if (addr < DEPTH) mem_m[addr] = d;
        else err_m = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        res = 1'b0;
        step();
        step();
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", ready);
        else pass_cnt++;
        total_cnt++;
        if (clrBusyCount !== '0) $display("FAIL reset_count: got %0d expected 0", clrBusyCount);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
        else pass_cnt++;
        res   = 1'b1;
        err_m = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            selData  = 1'b1;
            ldData   = 1'b1;
            dataAddr = AW'($urandom_range(DEPTH - 1, 0));
            #1;
            total_cnt++;
            if (dataOut !== '0) $display("FAIL sweep_load_zero: got %h expected 0000", dataOut);
            else pass_cnt++;
            step();
            total_cnt++;
            if (ready !== (k == DEPTH)) $display("FAIL sweep_ready_%0d: got %b expected %b", k, ready, k == DEPTH);
            else pass_cnt++;
            total_cnt++;
            if (clrBusyCount !== AW'(k % DEPTH)) $display("FAIL sweep_count_%0d: got %0d expected %0d", k, clrBusyCount, k % DEPTH);
            else pass_cnt++;
        end
        idle_inputs();
        model_clear();
        total_cnt++;
        if (err !== 1'b0) $display("FAIL sweep_err: got %b expected 0", err);
        else pass_cnt++;
    endtask

    task automatic test_store_load();
        do_store(5, 16'hBEEF);
        do_store(DEPTH - 1, 16'hC0DE);
        selData = 1'b1;
        ldData  = 1'b1;
        dataAddr = 12'h005;
        #1;
        total_cnt++;
        if (dataOut !== 16'hBEEF) $display("FAIL load_005: got %h expected beef", dataOut);
        else pass_cnt++;
        dataAddr = 12'h006;
        #1;
        total_cnt++;
        if (dataOut !== 16'h0000) $display("FAIL load_006: got %h expected 0000", dataOut);
        else pass_cnt++;
        dataAddr = AW'(DEPTH - 1);
        #1;
        total_cnt++;
        if (dataOut !== 16'hC0DE) $display("FAIL load_last: got %h expected c0de", dataOut);
        else pass_cnt++;
        ldData = 1'b0;
        #1;
        total_cnt++;
        if (dataOut !== 16'h0000) $display("FAIL store_sel_out: got %h expected 0000", dataOut);
        else pass_cnt++;
        step();
        mem_m[DEPTH - 1] = 16'h0000;
        idle_inputs();
    endtask

    task automatic run_sweep(input string tag);
        for (int k = 1; k <= DEPTH; k++) begin
            selData  = 1'b1;
            ldData   = 1'b1;
            dataAddr = 12'h00A;
            #1;
            total_cnt++;
            if (dataOut !== '0 || ready !== 1'b0)
                $display("FAIL %s_during_%0d: got data %h ready %b expected data 0000 ready 0", tag, k, dataOut, ready);
            else pass_cnt++;
            step();
        end
        idle_inputs();
        model_clear();
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL %s_ready_end: got %b expected 1", tag, ready);
        else pass_cnt++;
    endtask

    task automatic test_clear_after_data();
        do_store(10, 16'h1234);
        clrData = 1'b1;
        step();
        clrData = 1'b0;
        run_sweep("clr");
        selData  = 1'b1;
        ldData   = 1'b1;
        dataAddr = 12'h00A;
        #1;
        total_cnt++;
        if (dataOut !== 16'h0000) $display("FAIL clr_load_00a: got %h expected 0000", dataOut);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_clear_restart();
        clrData = 1'b1;
        step();
        clrData = 1'b0;
        for (int k = 0; k < 7; k++) step();
        total_cnt++;
        if (clrBusyCount !== AW'(7)) $display("FAIL restart_pre_count: got %0d expected 7", clrBusyCount);
        else pass_cnt++;
        clrData = 1'b1;
        step();
        clrData = 1'b0;
        total_cnt++;
        if (clrBusyCount !== '0 || ready !== 1'b0)
            $display("FAIL restart_count: got count %0d ready %b expected count 0 ready 0", clrBusyCount, ready);
        else pass_cnt++;
        run_sweep("restart");
    endtask

    task automatic test_clr_store_collision();
        do_store(3, 16'h9999);
        selData  = 1'b1;
        ldData   = 1'b0;
        dataAddr = 12'h003;
        dataIn   = 16'h5555;
        clrData  = 1'b1;
        step();
        idle_inputs();
        total_cnt++;
        if (ready !== 1'b0) $display("FAIL collide_ready: got %b expected 0", ready);
        else pass_cnt++;
        run_sweep("collide");
        selData  = 1'b1;
        ldData   = 1'b1;
        dataAddr = 12'h003;
        #1;
        total_cnt++;
        if (dataOut !== 16'h0000) $display("FAIL collide_load_003: got %h expected 0000", dataOut);
        else pass_cnt++;
        idle_inputs();
    endtask

    task automatic test_random();
        int            a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_d;
        for (int n = 0; n < 300; n++) begin
            a = $urandom_range(2 * DEPTH - 1, 0);
            d = DW'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                selData  = 1'b1;
                ldData   = 1'b1;
                dataAddr = AW'(a);
                #1;
                exp_d = (a < DEPTH) ? mem_m[a] : '0;
                total_cnt++;
                if (dataOut !== exp_d) $display("FAIL rand_load addr %0d: got %h expected %h", a, dataOut, exp_d);
                else pass_cnt++;
                step();
                if (a >= DEPTH) err_m = 1'b1;
            end else begin
                do_store(a, d);
            end
            total_cnt++;
            if (err !== err_m) $display("FAIL rand_err op %0d: got %b expected %b", n, err, err_m);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range();
        test_reset();
        do_store(0, 16'h7777);
        do_store(32, 16'hAAAA);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL oor_err_set: got %b expected 1", err);
        else pass_cnt++;
        do_store(DEPTH, 16'hAAAA);
        selData  = 1'b1;
        ldData   = 1'b1;
        dataAddr = 12'h000;
        #1;
        total_cnt++;
        if (dataOut !== 16'h7777) $display("FAIL oor_load_000: got %h expected 7777", dataOut);
        else pass_cnt++;
        dataAddr = 12'h020;
        #1;
        total_cnt++;
        if (dataOut !== 16'h0000) $display("FAIL oor_load_020: got %h expected 0000", dataOut);
        else pass_cnt++;
        idle_inputs();
        do_store(1, 16'h0101);
        clrData = 1'b1;
        step();
        clrData = 1'b0;
        for (int k = 0; k < DEPTH; k++) step();
        total_cnt++;
        if (err !== 1'b1 || ready !== 1'b1) $display("FAIL oor_err_sticky: got err %b ready %b expected err 1 ready 1", err, ready);
        else pass_cnt++;
        res = 1'b0;
        step();
        res = 1'b1;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL oor_err_cleared: got %b expected 0", err);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        err_m     = 1'b0;
        res       = 1'b0;
        idle_inputs();
        test_reset();
        test_store_load();
        test_clear_after_data();
        test_clear_restart();
        test_clr_store_collision();
        test_random();
        test_out_of_range();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
